dcim_sacc_ctrl: RTL and testbench

Bit-serial shift-and-accumulate sequencer for the DCIM macro. It accepts one signed partial sum per input bit-plane, MSB plane first, from the column adder tree. It accumulates them with doubling through the shared 24-bit `s_cla` carry-lookahead adder, applying the negative weight on the MSB plane for two's-complement inputs. It returns one 24-bit MAC result per operation over a valid/ready handshake.

---
 rtl/dcim_pkg.sv | 14 +
 rtl/s_cla.sv | 46 ++++
 rtl/dcim_sacc_ctrl.sv | 100 ++++++++++
 tb/tb_dcim_sacc_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcim_pkg.sv
// Shared DCIM definitions: sequencer state encoding and widths.
// Imported by the shift-and-accumulate control path.
package dcim_pkg;

  localparam int DCIM_ACC_W       = 24;
  localparam int DCIM_IN_BITS_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } sacc_state_t;

endpackage

// File: rtl/s_cla.sv
// Shared carry-lookahead adder: 4-bit lookahead groups,
// group carries chained. Carry-out provided, modulo 2^W sum.
module s_cla #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NG = W / 4;

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] c;
  logic         cg;
  logic         gg;
  logic         pp;

  assign g = a & b;
  assign p = a ^ b;

  // Bit carries inside a group depend only on the group carry-in.
  always_comb begin
    c  = '0;
    cg = cin;
    gg = 1'b0;
    pp = 1'b1;
    for (int grp = 0; grp < NG; grp++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int j = 0; j < 4; j++) begin
        c[grp*4+j] = gg | (pp & cg);
        gg = g[grp*4+j] | (p[grp*4+j] & gg);
        pp = pp & p[grp*4+j];
      end
      cg = gg | (pp & cg);
    end
  end

  assign sum  = p ^ c;
  assign cout = cg;

endmodule

// File: rtl/dcim_sacc_ctrl.sv
// Bit-serial shift-and-accumulate sequencer, MSB plane first,
// with negative MSB weight for two's-complement activations.
module dcim_sacc_ctrl
  import dcim_pkg::*;
#(
  parameter int IN_BITS = DCIM_IN_BITS_DEF,
  parameter int PSUM_W  = 16,
  parameter int ACC_W   = DCIM_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              signed_in,
  input  logic              clear,
  input  logic              psum_valid,
  input  logic [PSUM_W-1:0] psum,
  output logic              psum_ready,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result
);

  localparam int CW = $clog2(IN_BITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(IN_BITS - 1);

  sacc_state_t state;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             sgn;

  logic [ACC_W-1:0] op_a;
  logic [ACC_W-1:0] op_p;
  logic [ACC_W-1:0] op_b;
  logic [ACC_W-1:0] sum;
  logic             neg;
  logic             cout;

  assign op_a = {acc[ACC_W-2:0], 1'b0};
  assign op_p = ACC_W'($signed(psum));
  // MSB plane of a signed operand carries weight -2^(IN_BITS-1).
  assign neg  = sgn && (cnt == CNT_MAX);
  assign op_b = neg ? ~op_p : op_p;

  s_cla #(.W(ACC_W)) u_cla (
    .a   (op_a),
    .b   (op_b),
    .cin (neg),
    .sum (sum),
    .cout(cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      sgn   <= 1'b0;
    end else if (clear) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            sgn   <= signed_in;
            cnt   <= CNT_MAX;
            acc   <= '0;
            state <= S_ACC;
          end
        end
        S_ACC: begin
          if (psum_valid) begin
            acc <= sum;
            if (cnt == '0) state <= S_DONE;
            else           cnt   <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            if (start) begin
              sgn   <= signed_in;
              cnt   <= CNT_MAX;
              acc   <= '0;
              state <= S_ACC;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign psum_ready = (state == S_ACC);
  assign out_valid  = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign result     = acc;

endmodule

// File: tb/tb_dcim_sacc_ctrl.sv
// Directed bench for dcim_sacc_ctrl: vector table plus
// handshake, abort and wrap sequences.
module tb_dcim_sacc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_in = 1'b0;
  logic        clear = 1'b0;
  logic        psum_valid = 1'b0;
  logic [15:0] psum = '0;
  logic        psum_ready;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] result;

  logic        start10 = 1'b0;
  logic        pv10 = 1'b0;
  logic [15:0] ps10 = '0;
  logic        pr10;
  logic        busy10;
  logic        ov10;
  logic        or10 = 1'b0;
  logic [23:0] res10;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dcim_sacc_ctrl #(.IN_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .signed_in(signed_in), .clear(clear),
    .psum_valid(psum_valid), .psum(psum),
    .psum_ready(psum_ready), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
  );

  dcim_sacc_ctrl #(.IN_BITS(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start10),
    .signed_in(1'b0), .clear(1'b0),
    .psum_valid(pv10), .psum(ps10),
    .psum_ready(pr10), .busy(busy10),
    .out_valid(ov10), .out_ready(or10),
    .result(res10)
  );

  typedef struct {
    logic        sgn;
    logic [15:0] msb;
    logic [15:0] rest;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name,
                     input logic [23:0] act,
                     input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at the negedge after the start-capturing edge.
  task automatic feed(input logic [15:0] msb,
                      input logic [15:0] rest,
                      input bit gap,
                      output int lat);
    int beat;
    bit gapped;
    beat = 0;
    gapped = 0;
    lat = 0;
    start = 1'b0;
    while (!out_valid && lat < 60) begin
      if (psum_ready) begin
        psum = (beat == 0) ? msb : rest;
        if (gap && beat == 3 && !gapped) begin
          psum_valid = 1'b0;
          gapped = 1;
        end else begin
          psum_valid = 1'b1;
          beat++;
        end
      end else begin
        psum_valid = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    psum_valid = 1'b0;
  endtask

  task automatic run_op(input logic sgn,
                        input logic [15:0] msb,
                        input logic [15:0] rest,
                        input bit gap,
                        output logic [23:0] res,
                        output int lat);
    @(negedge clk);
    start = 1'b1;
    signed_in = sgn;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    feed(msb, rest, gap, lat);
    lat = lat + 1;
    res = result;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [23:0] r;
  logic [23:0] held;
  int lat;

  initial begin
    vecs[0] = '{1'b0, 16'h0001, 16'h0001, 24'h0000FF};
    vecs[1] = '{1'b1, 16'h0001, 16'h0000, 24'hFFFF80};
    vecs[2] = '{1'b1, 16'hFFFD, 16'hFFFD, 24'h000003};
    vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, 24'hFFFF80};
    vecs[4] = '{1'b1, 16'h7FFF, 16'h7FFF, 24'hFF8001};
    vecs[5] = '{1'b0, 16'h0000, 16'h0002, 24'h0000FE};
    vecs[6] = '{1'b1, 16'hFFFF, 16'h0000, 24'h000080};

    #12;
    chk("reset_result", result, 24'h0);
    chk("reset_flags", {21'b0, psum_ready, out_valid, busy}, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].sgn, vecs[i].msb, vecs[i].rest, 0, r, lat);
      chk($sformatf("vec%0d_result", i), r, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 24'(lat), 24'd9);
      drain();
      chk($sformatf("vec%0d_idle", i), {23'b0, busy}, 24'h0);
    end

    // psum_valid bubble mid-run must not change the result.
    run_op(1'b0, 16'h0001, 16'h0001, 1, r, lat);
    chk("gap_result", r, 24'h0000FF);
    chk("gap_latency", 24'(lat), 24'd10);

    // Output backpressure: hold, with start ignored.
    held = result;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_result", result, held);
      chk("bp_flags", {21'b0, psum_ready, out_valid, busy}, 24'h3);
    end
    start = 1'b0;
    drain();
    chk("bp_idle", {23'b0, busy}, 24'h0);

    // Back-to-back: out_ready with start goes straight to ACC.
    run_op(1'b1, 16'h0001, 16'h0000, 0, r, lat);
    chk("b2b_first", r, 24'hFFFF80);
    out_ready = 1'b1;
    start = 1'b1;
    signed_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_no_idle", {22'b0, psum_ready, busy}, 24'h3);
    feed(16'h0001, 16'h0001, 0, lat);
    chk("b2b_second", result, 24'h0000FF);
    chk("b2b_latency", 24'(lat), 24'd8);
    drain();

    // Clear after four beats, then a fresh operation.
    start = 1'b1;
    signed_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    psum = 16'h0005;
    psum_valid = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    psum_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    chk("clear_flags", {21'b0, psum_ready, out_valid, busy}, 24'h0);
    run_op(1'b1, 16'hFFFD, 16'hFFFD, 0, r, lat);
    chk("clear_fresh", r, 24'h000003);
    drain();

    // Asynchronous reset in the middle of ACC.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    psum = 16'h0001;
    psum_valid = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_result", result, 24'h0);
    chk("rst_flags", {21'b0, psum_ready, out_valid, busy}, 24'h0);
    psum_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // IN_BITS=10 wrap modulo 2^24.
    start10 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start10 = 1'b0;
    ps10 = 16'h7FFF;
    pv10 = 1'b1;
    lat = 0;
    while (!ov10 && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    pv10 = 1'b0;
    chk("wrap_result", res10, 24'hFF7C01);
    chk("wrap_valid", {23'b0, ov10}, 24'h1);
    chk("wrap_latency", 24'(lat), 24'd10);
    or10 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or10 = 1'b0;
    chk("wrap_idle", {23'b0, busy10}, 24'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
